// File: rtl/swap_pkg.sv
// Shared definitions for the swap request queue.
//   state_t             : controller states
//   SWAP_CYCLES_DEFAULT : register-file swap sequence length (sel = 1..3)
//   SCRATCH_ADDR        : register-file scratch slot, never a legal swap operand
//   swap_entry_t        : queue entry at the default address width
package swap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned SWAP_CYCLES_DEFAULT = 3;
  localparam int unsigned SCRATCH_ADDR        = 0;
  localparam int unsigned ADDR_WIDTH_DEFAULT  = 7;

  typedef struct packed {
    logic [ADDR_WIDTH_DEFAULT-1:0] addr_a;
    logic [ADDR_WIDTH_DEFAULT-1:0] addr_b;
  } swap_entry_t;

endpackage

// File: rtl/swap_req_fifo.sv
// Synchronous FIFO for pending swap requests.
//   clk, reset_n : clock, async active-low reset
//   push, pop    : write / read strobes (ignored when full / empty)
//   din, dout    : entry in, head entry out (head valid when !empty)
//   count        : number of stored entries
//   full, empty  : derived from count, not from pointer equality
module swap_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  // No write while full, even if a pop happens in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; no reset needed, contents qualified by count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      if (w_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= CNT_W'(r_count + 1'b1);
        2'b01:   r_count <= CNT_W'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/swap_req_queue.sv
// Swap-port initiator: queues (A, B) requests and serialises them onto the
// register file's swap port, holding the addresses for the whole sequence.
//   clk, reset_n           : clock, async active-low reset
//   req_valid/req_ready    : request handshake; req_addr_a/b request payload
//   swap                   : one-cycle swap start to the register file
//   address_A/address_B    : operand addresses, change only on a pop
//   busy                   : register file ports borrowed (ISSUE + WAIT)
//   done/err               : retirement pulse, err marks a rejected request
//   count                  : queued entries, excluding the one in flight
module swap_req_queue
  import swap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SWAP_CYCLES = SWAP_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_WIDTH-1:0]      req_addr_a,
  input  logic [ADDR_WIDTH-1:0]      req_addr_b,
  output logic                       swap,
  output logic [ADDR_WIDTH-1:0]      address_A,
  output logic [ADDR_WIDTH-1:0]      address_B,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned WAIT_W = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
  } entry_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_W-1:0]     r_wait;
  logic [WAIT_W-1:0]     w_wait_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;

  entry_t                w_push_entry;
  entry_t                w_head;
  logic [2*ADDR_WIDTH-1:0] w_fifo_dout;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic                  w_reject;
  logic                  w_noop;

  assign w_push_entry = '{addr_a: req_addr_a, addr_b: req_addr_b};
  assign w_head       = entry_t'(w_fifo_dout);

  swap_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid),
    .pop     (w_pop),
    .din     (w_push_entry),
    .dout    (w_fifo_dout),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Scratch slot as an operand is an error; identical operands are a no-op.
  assign w_reject = (w_head.addr_a == ADDR_WIDTH'(SCRATCH_ADDR)) ||
                    (w_head.addr_b == ADDR_WIDTH'(SCRATCH_ADDR));
  assign w_noop   = (w_head.addr_a == w_head.addr_b);

  // State, wait counter, error flag and held addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_wait   <= '0;
      r_err    <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_err   <= w_err_nxt;
      if (w_pop) begin
        r_addr_a <= w_head.addr_a;
        r_addr_b <= w_head.addr_b;
      end
    end
  end

  // Next-state logic; a pop happens only from IDLE with a non-empty queue.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_err_nxt   = r_err;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_reject) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
          end else if (w_noop) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_err_nxt   = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_wait_nxt  = WAIT_W'(SWAP_CYCLES - 1);
      end
      ST_WAIT: begin
        if (r_wait == '0) w_state_nxt = ST_DONE;
        else              w_wait_nxt  = WAIT_W'(r_wait - 1'b1);
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  assign swap      = (r_state == ST_ISSUE);
  assign busy      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign done      = (r_state == ST_DONE);
  assign err       = (r_state == ST_DONE) && r_err;
  assign address_A = r_addr_a;
  assign address_B = r_addr_b;
  assign req_ready = !w_full;
  assign count     = w_count;

endmodule

// File: tb/tb_swap_req_queue.sv
// Scoreboard bench for swap_req_queue: the driver queues hand-computed
// expectations per request, a negedge monitor retires them on done.
module tb_swap_req_queue;

  localparam int unsigned AW = 7;
  localparam int unsigned DP = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr_a = '0;
  logic [AW-1:0] req_addr_b = '0;
  logic          swap;
  logic [AW-1:0] address_A;
  logic [AW-1:0] address_B;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    count;

  swap_req_queue #(.ADDR_WIDTH(AW), .DEPTH(DP), .SWAP_CYCLES(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .swap       (swap),
    .address_A  (address_A),
    .address_B  (address_B),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    bit            e;
    bit            s;
  } exp_t;

  exp_t exp_q[$];
  int   swap_cyc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_left = 0;
  int   last_swap_cyc = 0;
  bit   swap_seen = 1'b0;
  bit   saw_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: retires expectations on done and checks per-cycle rules.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_left = 0;
      swap_seen = 1'b0;
    end else begin
      chk("ready_rule", 32'(req_ready), 32'(count != 3'(DP)));
      chk("count_max", 32'(count <= 3'(DP)), 32'd1);
      if (count == 3'(DP)) saw_full = 1'b1;
      if (swap) begin
        swap_seen = 1'b1;
        last_swap_cyc = cyc;
        swap_cyc_q.push_back(cyc);
        busy_left = 4;
        if (exp_q.size() != 0) begin
          chk("swap_addr_a", 32'(address_A), 32'(exp_q[0].a));
          chk("swap_addr_b", 32'(address_B), 32'(exp_q[0].b));
        end
      end
      chk("busy", 32'(busy), 32'(busy_left > 0));
      if (busy_left > 0) busy_left--;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_err", 32'(err), 32'(e.e));
          chk("done_addr_a", 32'(address_A), 32'(e.a));
          chk("done_addr_b", 32'(address_B), 32'(e.b));
          chk("done_swapped", 32'(swap_seen), 32'(e.s));
          if (e.s) chk("swap_to_done", 32'(cyc - last_swap_cyc), 32'd4);
        end
        swap_seen = 1'b0;
      end
    end
  end

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_req(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input bit e, input bit s, output int acc_cyc);
    int  tries = 0;
    bit  ok = 1'b0;
    exp_t x;
    acc_cyc = -1;
    req_valid  = 1'b1;
    req_addr_a = a;
    req_addr_b = b;
    while (!ok) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        x.a = a; x.b = b; x.e = e; x.s = s;
        exp_q.push_back(x);
      end
      @(posedge clk);
      #1;
      tries++;
      if (!ok && tries > 300) begin
        chk("push_timeout", 32'd1, 32'd0);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_swap"}, 32'(swap), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_addr_a"}, 32'(address_A), 32'd0);
    chk({tag, "_addr_b"}, 32'(address_B), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Single (5, 9) swap with explicit cycle-by-cycle timing checks.
  task automatic run_single(input string tag);
    int c0;
    push_req(7'd5, 7'd9, 1'b0, 1'b1, c0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk({tag, "_cyc"}, 32'(cyc - c0), 32'(k));
      chk({tag, "_swap"}, 32'(swap), 32'(k == 2));
      chk({tag, "_busy"}, 32'(busy), 32'(k >= 2 && k <= 5));
      chk({tag, "_done"}, 32'(done), 32'(k == 6));
      if (k >= 2) begin
        chk({tag, "_hold_a"}, 32'(address_A), 32'd5);
        chk({tag, "_hold_b"}, 32'(address_B), 32'd9);
      end
    end
    wait_drain();
  endtask

  initial begin
    int c;
    logic [AW-1:0] fa [5];
    logic [AW-1:0] fb [5];
    fa = '{7'd1, 7'd3, 7'd5, 7'd8, 7'd10};
    fb = '{7'd2, 7'd4, 7'd6, 7'd9, 7'd11};

    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    run_single("single");

    // Queue fill: five held requests, DEPTH = 4.
    saw_full = 1'b0;
    swap_cyc_q.delete();
    for (int i = 0; i < 5; i++) push_req(fa[i], fb[i], 1'b0, 1'b1, c);
    wait_drain();
    chk("fill_saw_full", 32'(saw_full), 32'd1);
    chk("fill_swaps", 32'(swap_cyc_q.size()), 32'd5);
    for (int i = 1; i < swap_cyc_q.size(); i++)
      chk("fill_spacing", 32'(swap_cyc_q[i] - swap_cyc_q[i-1]), 32'd6);

    // Rejections: scratch operand errors, identical operands are a no-op.
    swap_cyc_q.delete();
    push_req(7'd0, 7'd3, 1'b1, 1'b0, c);
    push_req(7'd7, 7'd7, 1'b0, 1'b0, c);
    push_req(7'd4, 7'd0, 1'b1, 1'b0, c);
    wait_drain();
    chk("reject_no_swap", 32'(swap_cyc_q.size()), 32'd0);

    // Ten requests at full throughput: push and pop overlap, pointers wrap.
    for (int i = 0; i < 10; i++)
      push_req(7'(20 + i), 7'(40 + i), 1'b0, 1'b1, c);
    wait_drain();

    // Reset during WAIT (C4): everything returns to reset values.
    push_req(7'd5, 7'd9, 1'b0, 1'b1, c);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    chk("midwait_busy", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1 check_reset_vals("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    run_single("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
